// File: rtl/l2_mem_banked_mp.sv
// rtl/l2_mem_banked_mp.sv - word-interleaved multi-port banked L2 SRAM array with per-bank round-robin arbitration
// Optional per-bank conflict counters are built when L2_MEM_PERF_CNT_EN is defined.
module l2_mem_banked_mp #(
  parameter int N_PORTS      = 2,
  parameter int DATA_WIDTH   = 64,
  parameter int N_BANKS      = 4,
  parameter int CUT_N_WORDS  = 16384,
  parameter int N_SER_CUTS   = 2,
  parameter int SRAM_LATENCY = 1,
  localparam int ADDR_WIDTH  = $clog2(N_BANKS * N_SER_CUTS * CUT_N_WORDS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [N_PORTS-1:0]                    req_i,
  output logic [N_PORTS-1:0]                    gnt_o,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [N_PORTS-1:0]                    we_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
  output logic [N_PORTS-1:0]                    rvalid_o,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
  input  logic                                  perf_clr_i,
  output logic [N_BANKS-1:0][31:0]              perf_conflicts_o
);
  localparam int BANK_BITS = $clog2(N_BANKS);
  localparam int WORD_W    = $clog2(CUT_N_WORDS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = (N_SER_CUTS > 1) ? $clog2(N_SER_CUTS) : 1;
  localparam int PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int LAT       = SRAM_LATENCY;

  localparam bit PARAMS_OK = (N_PORTS >= 1) && (DATA_WIDTH >= 8) && (SRAM_LATENCY >= 1) &&
                             (N_SER_CUTS >= 1) && ((DATA_WIDTH & (DATA_WIDTH - 1)) == 0) &&
                             ((N_BANKS & (N_BANKS - 1)) == 0) && (N_BANKS >= 1) &&
                             ((CUT_N_WORDS & (CUT_N_WORDS - 1)) == 0) && (CUT_N_WORDS >= 2) &&
                             ((N_SER_CUTS & (N_SER_CUTS - 1)) == 0);
  if (!PARAMS_OK) begin : g_bad_params
    $error("l2_mem_banked_mp: illegal parameter set");
  end

  logic [N_PORTS-1:0][BANK_W-1:0] p_bank;
  logic [N_PORTS-1:0][WORD_W-1:0] p_word;
  logic [N_PORTS-1:0][ROW_W-1:0]  p_row;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      p_bank[p] = BANK_W'(addr_i[p] & ADDR_WIDTH'(N_BANKS - 1));
      p_word[p] = WORD_W'(addr_i[p] >> BANK_BITS);
      p_row[p]  = ROW_W'((addr_i[p] >> (BANK_BITS + WORD_W)) & ADDR_WIDTH'(N_SER_CUTS - 1));
    end
  end

  logic [N_BANKS-1:0][PORT_W-1:0]     rr_q, rr_d;
  logic [N_BANKS-1:0]                 bk_gnt;
  logic [N_BANKS-1:0][PORT_W-1:0]     bk_port;
  logic [N_BANKS-1:0]                 bk_we;
  logic [N_BANKS-1:0][WORD_W-1:0]     bk_word;
  logic [N_BANKS-1:0][ROW_W-1:0]      bk_row;
  logic [N_BANKS-1:0][DATA_WIDTH-1:0] bk_wdata;
  logic [N_BANKS-1:0][BE_W-1:0]       bk_be;

  // Each bank scans ports starting at its pointer; the first requester targeting it wins.
  always_comb begin
    int p;
    p        = 0;
    gnt_o    = '0;
    rr_d     = rr_q;
    bk_gnt   = '0;
    bk_port  = '0;
    bk_we    = '0;
    bk_word  = '0;
    bk_row   = '0;
    bk_wdata = '0;
    bk_be    = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        p = (int'(rr_q[b]) + i) % N_PORTS;
        if (!rst_i && !bk_gnt[b] && req_i[p] && (p_bank[p] == BANK_W'(b))) begin
          bk_gnt[b]   = 1'b1;
          bk_port[b]  = PORT_W'(p);
          bk_we[b]    = we_i[p];
          bk_word[b]  = p_word[p];
          bk_row[b]   = p_row[p];
          bk_wdata[b] = wdata_i[p];
          bk_be[b]    = be_i[p];
          gnt_o[p]    = 1'b1;
          rr_d[b]     = PORT_W'((p + 1) % N_PORTS);
        end
      end
    end
  end

  logic [N_BANKS-1:0][LAT-1:0]             vld_q, vld_d;
  logic [N_BANKS-1:0][LAT-1:0]             we_q, we_d;
  logic [N_BANKS-1:0][LAT-1:0][PORT_W-1:0] port_q, port_d;
  logic [N_BANKS-1:0][LAT-1:0][ROW_W-1:0]  row_q, row_d;

  always_comb begin
    vld_d  = vld_q;
    we_d   = we_q;
    port_d = port_q;
    row_d  = row_q;
    for (int b = 0; b < N_BANKS; b++) begin
      vld_d[b][0]  = bk_gnt[b];
      we_d[b][0]   = bk_we[b];
      port_d[b][0] = bk_port[b];
      row_d[b][0]  = bk_row[b];
      for (int s = 1; s < LAT; s++) begin
        vld_d[b][s]  = vld_q[b][s-1];
        we_d[b][s]   = we_q[b][s-1];
        port_d[b][s] = port_q[b][s-1];
        row_d[b][s]  = row_q[b][s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      vld_q <= '0;
    end else begin
      rr_q  <= rr_d;
      vld_q <= vld_d;
    end
    we_q   <= we_d;
    port_q <= port_d;
    row_q  <= row_d;
  end

  logic [DATA_WIDTH-1:0] cut_out [N_BANKS][N_SER_CUTS];

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    for (genvar r = 0; r < N_SER_CUTS; r++) begin : g_cut
      logic [DATA_WIDTH-1:0]          mem [CUT_N_WORDS];
      logic [LAT-1:0][DATA_WIDTH-1:0] rd_q;
      logic                           cut_req;

      assign cut_req    = bk_gnt[b] && (bk_row[b] == ROW_W'(r));
      assign cut_out[b][r] = rd_q[LAT-1];

      // Cut model: one registered read stage plus LAT-1 output delay stages.
      always_ff @(posedge clk_i) begin
        if (cut_req) begin
          if (bk_we[b]) begin
            for (int i = 0; i < BE_W; i++) begin
              if (bk_be[b][i]) mem[bk_word[b]][i*8 +: 8] <= bk_wdata[b][i*8 +: 8];
            end
          end else begin
            rd_q[0] <= mem[bk_word[b]];
          end
        end
        for (int s = 1; s < LAT; s++) rd_q[s] <= rd_q[s-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (vld_q[b][LAT-1]) begin
        for (int p = 0; p < N_PORTS; p++) begin
          if (port_q[b][LAT-1] == PORT_W'(p)) begin
            rvalid_o[p] = 1'b1;
            if (!we_q[b][LAT-1]) rdata_o[p] = cut_out[b][row_q[b][LAT-1]];
          end
        end
      end
    end
  end

`ifdef L2_MEM_PERF_CNT_EN
  logic [N_BANKS-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    int n;
    n     = 0;
    cnt_d = cnt_q;
    for (int b = 0; b < N_BANKS; b++) begin
      n = 0;
      for (int p = 0; p < N_PORTS; p++) begin
        if (req_i[p] && (p_bank[p] == BANK_W'(b))) n++;
      end
      if (perf_clr_i) cnt_d[b] = '0;
      else if ((n >= 2) && (cnt_q[b] != 32'hFFFF_FFFF)) cnt_d[b] = cnt_q[b] + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign perf_conflicts_o = cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr  = perf_clr_i;
  assign perf_conflicts_o = '0;
`endif

endmodule
